pmp_phase_fetch_sched: RTL



---
 rtl/pmp_phase_fetch_sched_pkg.sv | 45 ++++
 rtl/pmp_phase_fetch_sched_if.sv | 24 ++
 rtl/pmp_phase_fetch_sched.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pmp_phase_fetch_sched_pkg.sv
// Shared types and DataMover field layout for the phase fetch scheduler.
//   state_t      : scheduler FSM states
//   CMD_* / STS_*: MM2S command and status bit positions and masks
//   dm_cmd_build : packs one 72-bit MM2S command (INCR, EOF set)
package pmp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_CREDIT,
        ST_DRAIN,
        ST_ABORT
    } state_t;

    localparam int CMD_W        = 72;
    localparam int CMD_BTT_LSB  = 0;
    localparam int CMD_BTT_W    = 23;
    localparam int CMD_TYPE_BIT = 23;
    localparam int CMD_EOF_BIT  = 30;
    localparam int CMD_ADDR_LSB = 32;
    localparam int CMD_ADDR_W   = 32;
    localparam int CMD_TAG_LSB  = 64;
    localparam int CMD_TAG_W    = 4;

    localparam int         STS_W         = 8;
    localparam logic [7:0] STS_OKAY_MASK = 8'h80;
    localparam logic [7:0] STS_ERR_MASK  = 8'h70;
    localparam logic [7:0] STS_TAG_MASK  = 8'h0F;

    function automatic logic [CMD_W-1:0] dm_cmd_build(
        input logic [CMD_ADDR_W-1:0] addr,
        input logic [CMD_BTT_W-1:0]  btt,
        input logic [CMD_TAG_W-1:0]  tag
    );
        logic [CMD_W-1:0] c;
        c = '0;
        c[CMD_BTT_LSB +: CMD_BTT_W]   = btt;
        c[CMD_TYPE_BIT]               = 1'b1;
        c[CMD_EOF_BIT]                = 1'b1;
        c[CMD_ADDR_LSB +: CMD_ADDR_W] = addr;
        c[CMD_TAG_LSB +: CMD_TAG_W]   = tag;
        return c;
    endfunction

endpackage

// File: rtl/pmp_phase_fetch_sched_if.sv
// DataMover MM2S command and status streams.
//   master : scheduler side (drives command, accepts status)
//   slave  : DataMover side
interface pmp_phase_fetch_sched_if;
    import pmp_pkg::*;

    logic [CMD_W-1:0] m_axis_cmd_tdata;
    logic             m_axis_cmd_tvalid;
    logic             m_axis_cmd_tready;
    logic [STS_W-1:0] s_axis_sts_tdata;
    logic             s_axis_sts_tvalid;
    logic             s_axis_sts_tready;

    modport master (
        output m_axis_cmd_tdata, m_axis_cmd_tvalid, s_axis_sts_tready,
        input  m_axis_cmd_tready, s_axis_sts_tdata, s_axis_sts_tvalid
    );

    modport slave (
        input  m_axis_cmd_tdata, m_axis_cmd_tvalid, s_axis_sts_tready,
        output m_axis_cmd_tready, s_axis_sts_tdata, s_axis_sts_tvalid
    );

endinterface

// File: rtl/pmp_phase_fetch_sched.sv
// Read scheduler for the absolute-phase unwrap stage. Issues MM2S commands
// line-interleaved across the three wrapped-phase images, limits lines in
// flight by a credit count, checks returned statuses in order and finishes
// once all statuses and all unwrapped result lines are back.
//   aclk/areset       : clock, synchronous active-high reset
//   cfg_*             : run configuration, latched on an accepted cfg_start
//   dm                : MM2S command out / status in
//   res_line_done     : one pulse per unwrapped output line
//   busy/done/err     : run status; lines_done counts returned result lines
module pmp_phase_fetch_sched
    import pmp_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int BTT_WIDTH       = 23,
    parameter int LINE_CNT_WIDTH  = 16
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      cfg_start,
    input  logic [ADDR_WIDTH-1:0]     cfg_base0,
    input  logic [ADDR_WIDTH-1:0]     cfg_base1,
    input  logic [ADDR_WIDTH-1:0]     cfg_base2,
    input  logic [BTT_WIDTH-1:0]      cfg_line_bytes,
    input  logic [LINE_CNT_WIDTH-1:0] cfg_line_num,
    input  logic [ADDR_WIDTH-1:0]     cfg_line_stride,
    pmp_phase_fetch_sched_if.master   dm,
    input  logic                      res_line_done,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [LINE_CNT_WIDTH-1:0] lines_done
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int SC_W  = LINE_CNT_WIDTH + 2;
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    state_t                    state, state_n;
    logic [1:0]                p, p_n, sts_p, sts_p_n, sts_line, sts_line_n;
    logic [LINE_CNT_WIDTH-1:0] line, line_n, line_num_q, line_num_n;
    logic [LINE_CNT_WIDTH-1:0] lines_done_n;
    logic [OUT_W-1:0]          outstanding, outstanding_n;
    logic [SC_W-1:0]           sts_cnt, sts_cnt_n, sts_total;
    logic [ADDR_WIDTH-1:0]     addr0, addr1, addr2, addr0_n, addr1_n, addr2_n;
    logic [ADDR_WIDTH-1:0]     stride_q, stride_n, addr_sel;
    logic [BTT_WIDTH-1:0]      bytes_q, bytes_n;
    logic                      tvalid, tvalid_n, busy_n, done_n, err_n;
    logic                      hs, active, res_ok, inc, sts_take, sts_bad;

    assign dm.s_axis_sts_tready = 1'b1;
    assign dm.m_axis_cmd_tvalid = tvalid;

    // tdata comes straight from registers that only move on a handshake,
    // so it stays stable while tvalid waits for tready.
    always_comb begin
        case (p)
            2'd0:    addr_sel = addr0;
            2'd1:    addr_sel = addr1;
            default: addr_sel = addr2;
        endcase
    end
    assign dm.m_axis_cmd_tdata = dm_cmd_build(CMD_ADDR_W'(addr_sel), CMD_BTT_W'(bytes_q),
                                              {line[1:0], p});

    assign sts_total = ({2'b00, line_num_q} << 1) + {2'b00, line_num_q};
    assign hs        = tvalid & dm.m_axis_cmd_tready;
    assign active    = state inside {ST_ISSUE, ST_WAIT_CREDIT, ST_DRAIN};
    assign res_ok    = active & res_line_done & (outstanding != '0);
    assign inc       = (state == ST_ISSUE) & hs & (p == 2'd2);
    assign sts_take  = active & dm.s_axis_sts_tvalid;
    // Statuses return in command order, so the expected tag is a simple walk.
    assign sts_bad   = sts_take & (((dm.s_axis_sts_tdata & STS_OKAY_MASK) == '0) ||
                                   ((dm.s_axis_sts_tdata & STS_ERR_MASK) != '0) ||
                                   ((dm.s_axis_sts_tdata & STS_TAG_MASK) != {4'h0, sts_line, sts_p}) ||
                                   (sts_cnt == sts_total));

    always_comb begin
        state_n      = state;
        p_n          = p;
        line_n       = line;
        line_num_n   = line_num_q;
        bytes_n      = bytes_q;
        stride_n     = stride_q;
        addr0_n      = addr0;
        addr1_n      = addr1;
        addr2_n      = addr2;
        tvalid_n     = tvalid;
        busy_n       = busy;
        done_n       = 1'b0;
        err_n        = err;
        lines_done_n = lines_done + LINE_CNT_WIDTH'(res_ok);
        sts_cnt_n    = sts_cnt;
        sts_p_n      = sts_p;
        sts_line_n   = sts_line;
        outstanding_n = outstanding;
        if (inc && !res_ok)      outstanding_n = outstanding + OUT_W'(1);
        else if (!inc && res_ok) outstanding_n = outstanding - OUT_W'(1);
        if (sts_take && !sts_bad) begin
            sts_cnt_n  = sts_cnt + SC_W'(1);
            sts_p_n    = (sts_p == 2'd2) ? 2'd0 : sts_p + 2'd1;
            sts_line_n = sts_line + {1'b0, sts_p == 2'd2};
        end

        case (state)
            ST_IDLE: if (cfg_start) begin
                line_num_n    = cfg_line_num;
                bytes_n       = cfg_line_bytes;
                stride_n      = cfg_line_stride;
                addr0_n       = cfg_base0;
                addr1_n       = cfg_base1;
                addr2_n       = cfg_base2;
                p_n           = '0;
                line_n        = '0;
                outstanding_n = '0;
                sts_cnt_n     = '0;
                sts_p_n       = '0;
                sts_line_n    = '0;
                lines_done_n  = '0;
                err_n         = 1'b0;
                if (cfg_line_bytes == '0) begin
                    err_n  = 1'b1;
                    done_n = 1'b1;
                end else if (cfg_line_num == '0) begin
                    done_n = 1'b1;
                end else begin
                    // Counters were just cleared, so the first line always has credit.
                    busy_n   = 1'b1;
                    tvalid_n = 1'b1;
                    state_n  = ST_ISSUE;
                end
            end
            ST_ISSUE: if (hs) begin
                if (p == 2'd2) begin
                    p_n     = '0;
                    line_n  = line + LINE_CNT_WIDTH'(1);
                    addr0_n = addr0 + stride_q;
                    addr1_n = addr1 + stride_q;
                    addr2_n = addr2 + stride_q;
                    if (line == line_num_q - LINE_CNT_WIDTH'(1)) begin
                        tvalid_n = 1'b0;
                        state_n  = ST_DRAIN;
                    end else if (outstanding_n >= MAX_OUT) begin
                        tvalid_n = 1'b0;
                        state_n  = ST_WAIT_CREDIT;
                    end
                end else begin
                    p_n = p + 2'd1;
                end
            end
            ST_WAIT_CREDIT: if (outstanding_n < MAX_OUT) begin
                tvalid_n = 1'b1;
                state_n  = ST_ISSUE;
            end
            ST_DRAIN: if (sts_cnt == sts_total && lines_done == line_num_q) begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            ST_ABORT: if (!tvalid || hs) begin
                tvalid_n = 1'b0;
                done_n   = 1'b1;
                busy_n   = 1'b0;
                state_n  = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        // A bad status wins over everything else: only a command already
        // presented may still complete.
        if (sts_bad) begin
            err_n    = 1'b1;
            done_n   = 1'b0;
            busy_n   = 1'b1;
            tvalid_n = tvalid & ~hs;
            state_n  = ST_ABORT;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= ST_IDLE;
            p           <= '0;
            line        <= '0;
            line_num_q  <= '0;
            bytes_q     <= '0;
            stride_q    <= '0;
            addr0       <= '0;
            addr1       <= '0;
            addr2       <= '0;
            tvalid      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            lines_done  <= '0;
            outstanding <= '0;
            sts_cnt     <= '0;
            sts_p       <= '0;
            sts_line    <= '0;
        end else begin
            state       <= state_n;
            p           <= p_n;
            line        <= line_n;
            line_num_q  <= line_num_n;
            bytes_q     <= bytes_n;
            stride_q    <= stride_n;
            addr0       <= addr0_n;
            addr1       <= addr1_n;
            addr2       <= addr2_n;
            tvalid      <= tvalid_n;
            busy        <= busy_n;
            done        <= done_n;
            err         <= err_n;
            lines_done  <= lines_done_n;
            outstanding <= outstanding_n;
            sts_cnt     <= sts_cnt_n;
            sts_p       <= sts_p_n;
            sts_line    <= sts_line_n;
        end
    end

endmodule
